// File: rtl/gamepad_pmod_rx.sv
// gamepad_pmod_rx
//   Receives the SNES-style serial button frame arriving on a PMOD header and
//   presents the accepted button state with per-bit press/release pulses.
//
//   Parameters
//     NUM_PADS       controllers in one serial frame (1..4)
//     BITS_PER_PAD   button bits per controller
//     TIMEOUT_CYCLES clk cycles without a valid frame before link loss (>= 2)
//
//   Ports
//     clk          system clock, rising edge
//     rst_n        synchronous active-low reset
//     pmod_data    serial data (asynchronous)
//     pmod_clk     shift clock (asynchronous), bit taken on its falling edge
//     pmod_latch   frame latch (asynchronous), frame closed on its rising edge
//     buttons      last accepted button state, first bit received in the MSB
//     pressed      one-cycle pulse per bit that went 0->1
//     released     one-cycle pulse per bit that went 1->0
//     frame_valid  one-cycle pulse when a frame is accepted
//     frame_error  one-cycle pulse when a frame is rejected
//     link_up      high once frames arrive
//
//   Build option
//     GAMEPAD_RX_WATCHDOG_EN  when defined, link_up drops and buttons are
//                             released after TIMEOUT_CYCLES without a frame.
//                             When undefined, link_up stays high until reset.

module gamepad_pmod_rx #(
    parameter int unsigned NUM_PADS       = 2,
    parameter int unsigned BITS_PER_PAD   = 12,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             pmod_data,
    input  logic                             pmod_clk,
    input  logic                             pmod_latch,
    output logic [NUM_PADS*BITS_PER_PAD-1:0] buttons,
    output logic [NUM_PADS*BITS_PER_PAD-1:0] pressed,
    output logic [NUM_PADS*BITS_PER_PAD-1:0] released,
    output logic                             frame_valid,
    output logic                             frame_error,
    output logic                             link_up
);

    localparam int unsigned W  = NUM_PADS * BITS_PER_PAD;
    // Counter must hold W+1 so an over-long frame can never alias to W.
    localparam int unsigned CW = $clog2(W + 2);

    if (NUM_PADS < 1 || NUM_PADS > 4 || BITS_PER_PAD < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("gamepad_pmod_rx: illegal parameter value");
    end

    logic          data_meta, data_sync;
    logic          sclk_meta, sclk_sync, sclk_prev;
    logic          latch_meta, latch_sync, latch_prev;
    logic [W-1:0]  shift_reg;
    logic [CW-1:0] bit_cnt;

    logic clk_fall;
    logic latch_rise;
    logic accept;

    assign clk_fall   = sclk_prev & ~sclk_sync;
    assign latch_rise = latch_sync & ~latch_prev;
    // Latch is judged on the pre-shift count even if a bit arrives in the same cycle.
    assign accept     = latch_rise && (bit_cnt == CW'(W));

`ifdef GAMEPAD_RX_WATCHDOG_EN
    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_meta   <= 1'b0;
            data_sync   <= 1'b0;
            sclk_meta   <= 1'b0;
            sclk_sync   <= 1'b0;
            sclk_prev   <= 1'b0;
            latch_meta  <= 1'b0;
            latch_sync  <= 1'b0;
            latch_prev  <= 1'b0;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            buttons     <= '0;
            pressed     <= '0;
            released    <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            link_up     <= 1'b0;
`ifdef GAMEPAD_RX_WATCHDOG_EN
            wd_cnt      <= '0;
`endif
        end else begin
            data_meta  <= pmod_data;
            data_sync  <= data_meta;
            sclk_meta  <= pmod_clk;
            sclk_sync  <= sclk_meta;
            sclk_prev  <= sclk_sync;
            latch_meta <= pmod_latch;
            latch_sync <= latch_meta;
            latch_prev <= latch_sync;

            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            pressed     <= '0;
            released    <= '0;

            if (accept) begin
                buttons     <= shift_reg;
                pressed     <= shift_reg & ~buttons;
                released    <= ~shift_reg & buttons;
                frame_valid <= 1'b1;
            end else if (latch_rise) begin
                frame_error <= 1'b1;
            end

            if (clk_fall) begin
                shift_reg <= W'({shift_reg, data_sync});
                if (latch_rise)
                    bit_cnt <= CW'(1);
                else if (bit_cnt != CW'(W + 1))
                    bit_cnt <= bit_cnt + CW'(1);
            end else if (latch_rise) begin
                bit_cnt <= '0;
            end

            if (frame_valid)
                link_up <= 1'b1;

`ifdef GAMEPAD_RX_WATCHDOG_EN
            // Count saturates at TIMEOUT_CYCLES so the timeout fires only once.
            if (frame_valid) begin
                wd_cnt <= WDW'(1);
            end else if (wd_cnt != WDW'(TIMEOUT_CYCLES)) begin
                wd_cnt <= wd_cnt + WDW'(1);
                if (wd_cnt == WDW'(TIMEOUT_CYCLES - 1) && !accept) begin
                    link_up  <= 1'b0;
                    buttons  <= '0;
                    pressed  <= '0;
                    released <= buttons;
                end
            end
`endif
        end
    end

endmodule
